// File: rtl/mips_bus_pkg.sv
// Shared types for the CPU memory bus: arbiter FSM states, grant owner and the
// latched bus command, which the load/store unit also uses.
package mips_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY_I,
    ST_BUSY_D,
    ST_DONE_I,
    ST_DONE_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam logic [3:0] BYTEEN_WORD = 4'b1111;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        is_write;
  } bus_cmd_t;

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// Signal bundle between the fetch/load-store masters, the arbiter and the slave.
// The arbiter connects through the slave modport; the environment uses master.
interface mips_bus_arbiter_if;

  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_readdata;
  logic        i_waitrequest;

  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_readdata;
  logic        d_waitrequest;

  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  logic        bus_error;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
           d_byteenable, waitrequest, readdata,
    output i_readdata, i_waitrequest, d_readdata, d_waitrequest,
           address, read, write, writedata, byteenable, bus_error
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
           d_byteenable, waitrequest, readdata,
    input  i_readdata, i_waitrequest, d_readdata, d_waitrequest,
           address, read, write, writedata, byteenable, bus_error
  );

endinterface

// File: rtl/bus_watchdog.sv
// Counts slave stall cycles of the current transaction; expires once
// TIMEOUT_CYCLES stalls have been tolerated and the slave is still stalling.
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic stall,
  output logic expire,
  output logic error
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  always_comb begin
    expire = stall && (cnt_q == LIMIT);
    cnt_d  = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (stall && !expire) begin
      cnt_d = cnt_q + 16'd1;
    end
    err_d = err_q | expire;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign error = err_q;

endmodule

// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-style bus between instruction fetch and
// load/store; one transaction in flight, registered completion per master.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               reset,
  mips_bus_arbiter_if.slave bus
);

  arb_state_t  state_q, state_d;
  grant_t      last_q, last_d;
  bus_cmd_t    cmd_q, cmd_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic i_req, d_req, busy;
  logic wd_start, wd_stall, wd_expire, wd_error;

  assign i_req    = bus.i_read;
  assign d_req    = bus.d_read | bus.d_write;
  assign busy     = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
  assign wd_stall = busy && bus.waitrequest;

  bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .start  (wd_start),
    .stall  (wd_stall),
    .expire (wd_expire),
    .error  (wd_error)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cmd_d     = cmd_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    wd_start  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // On a tie the master that did not win last time goes first.
        if (i_req && (!d_req || last_q == GRANT_D)) begin
          state_d        = ST_BUSY_I;
          last_d         = GRANT_I;
          cmd_d.addr     = bus.i_address;
          cmd_d.wdata    = '0;
          cmd_d.be       = BYTEEN_WORD;
          cmd_d.is_write = 1'b0;
          wd_start       = 1'b1;
        end else if (d_req) begin
          state_d        = ST_BUSY_D;
          last_d         = GRANT_D;
          cmd_d.addr     = bus.d_address;
          cmd_d.wdata    = bus.d_writedata;
          cmd_d.be       = bus.d_byteenable;
          cmd_d.is_write = bus.d_write;
          wd_start       = 1'b1;
        end
      end
      ST_BUSY_I: begin
        if (!bus.waitrequest) begin
          i_rdata_d = bus.readdata;
          state_d   = ST_DONE_I;
        end else if (wd_expire) begin
          i_rdata_d = '0;
          state_d   = ST_DONE_I;
        end
      end
      ST_BUSY_D: begin
        if (!bus.waitrequest) begin
          if (!cmd_q.is_write) begin
            d_rdata_d = bus.readdata;
          end
          state_d = ST_DONE_D;
        end else if (wd_expire) begin
          d_rdata_d = '0;
          state_d   = ST_DONE_D;
        end
      end
      ST_DONE_I, ST_DONE_D: state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      last_q    <= GRANT_D;
      cmd_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cmd_q     <= cmd_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Every output comes from a register or a state decode.
  assign bus.read          = busy && !cmd_q.is_write;
  assign bus.write         = busy && cmd_q.is_write;
  assign bus.address       = cmd_q.addr;
  assign bus.writedata     = cmd_q.wdata;
  assign bus.byteenable    = cmd_q.be;
  assign bus.i_waitrequest = (state_q != ST_DONE_I);
  assign bus.d_waitrequest = (state_q != ST_DONE_D);
  assign bus.i_readdata    = i_rdata_q;
  assign bus.d_readdata    = d_rdata_q;
  assign bus.bus_error     = wd_error;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed and random transactions against a transaction-level model of the
// arbiter: grant order, completion cycle, returned data and sticky error.
module tb_mips_bus_arbiter;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  // Model state: last winner (1 = data master), returned data, error flag.
  bit          last_g = 1'b1;
  logic [31:0] exp_ird = '0;
  logic [31:0] exp_drd = '0;
  logic        exp_err = 1'b0;

  mips_bus_arbiter_if bif ();

  mips_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_read"}, bif.read, 1'b0);
    chk({tag, "_write"}, bif.write, 1'b0);
    chk({tag, "_i_wait"}, bif.i_waitrequest, 1'b1);
    chk({tag, "_d_wait"}, bif.d_waitrequest, 1'b1);
  endtask

  // Called in an IDLE cycle N with the winner's request already driven.
  // stall = number of cycles the slave holds waitrequest high.
  task automatic txn(input bit is_d, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input bit wr, input int stall,
                     input logic [31:0] rdata);
    bit    abort;
    int    busy_len;
    string who;
    who      = is_d ? "d" : "i";
    abort    = (stall > TMO);
    busy_len = abort ? TMO + 1 : stall + 1;
    last_g   = is_d;
    tick();
    for (int j = 0; j < busy_len; j++) begin
      bif.waitrequest = (j < stall);
      bif.readdata    = (j < stall) ? $urandom : rdata;
      chk({who, "_busy_read"}, bif.read, !wr);
      chk({who, "_busy_write"}, bif.write, wr);
      chk({who, "_busy_addr"}, bif.address, addr);
      chk({who, "_busy_be"}, bif.byteenable, be);
      if (wr) chk({who, "_busy_wdata"}, bif.writedata, wd);
      chk({who, "_busy_i_wait"}, bif.i_waitrequest, 1'b1);
      chk({who, "_busy_d_wait"}, bif.d_waitrequest, 1'b1);
      chk({who, "_busy_err"}, bif.bus_error, exp_err);
      // Master inputs must be ignored while the command is in flight.
      if (is_d) bif.d_address = $urandom;
      else      bif.i_address = $urandom;
      tick();
    end
    bif.waitrequest = 1'b1;
    bif.readdata    = $urandom;
    if (abort) begin
      exp_err = 1'b1;
      if (is_d) exp_drd = '0; else exp_ird = '0;
    end else if (!wr) begin
      if (is_d) exp_drd = rdata; else exp_ird = rdata;
    end
    chk({who, "_done_i_wait"}, bif.i_waitrequest, is_d);
    chk({who, "_done_d_wait"}, bif.d_waitrequest, !is_d);
    chk({who, "_done_read"}, bif.read, 1'b0);
    chk({who, "_done_write"}, bif.write, 1'b0);
    chk({who, "_done_i_rdata"}, bif.i_readdata, exp_ird);
    chk({who, "_done_d_rdata"}, bif.d_readdata, exp_drd);
    chk({who, "_done_err"}, bif.bus_error, exp_err);
    if (is_d) begin
      bif.d_read  = 1'b0;
      bif.d_write = 1'b0;
    end else begin
      bif.i_read = 1'b0;
    end
    tick();
    chk_idle_outputs({who, "_idle"});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bif.i_read = 0; bif.i_address = '0;
    bif.d_read = 0; bif.d_write = 0; bif.d_address = '0;
    bif.d_writedata = '0; bif.d_byteenable = '0;
    bif.waitrequest = 1'b1; bif.readdata = '0;

    tick();
    tick();
    chk("rst_read", bif.read, 1'b0);
    chk("rst_write", bif.write, 1'b0);
    chk("rst_addr", bif.address, 32'h0);
    chk("rst_wdata", bif.writedata, 32'h0);
    chk("rst_be", bif.byteenable, 4'h0);
    chk("rst_i_wait", bif.i_waitrequest, 1'b1);
    chk("rst_d_wait", bif.d_waitrequest, 1'b1);
    chk("rst_i_rdata", bif.i_readdata, 32'h0);
    chk("rst_d_rdata", bif.d_readdata, 32'h0);
    chk("rst_err", bif.bus_error, 1'b0);
    reset = 1'b0;

    // Tie from reset: fetch first, then the write; a second tie goes to I again.
    bif.i_read = 1; bif.i_address = 32'hBFC0_0004;
    bif.d_write = 1; bif.d_address = 32'hBFC0_0010;
    bif.d_writedata = 32'hDEAD_BEEF; bif.d_byteenable = 4'h3;
    txn(0, 32'hBFC0_0004, 32'h0, 4'hF, 0, 0, 32'h1111_2222);
    txn(1, 32'hBFC0_0010, 32'hDEAD_BEEF, 4'h3, 1, 0, 32'h0);
    bif.i_read = 1; bif.i_address = 32'hBFC0_0008;
    bif.d_read = 1; bif.d_address = 32'h0000_0100; bif.d_byteenable = 4'hF;
    txn(0, 32'hBFC0_0008, 32'h0, 4'hF, 0, 1, 32'h3333_4444);
    txn(1, 32'h0000_0100, 32'h0, 4'hF, 0, 0, 32'h5555_6666);

    // Lone fetch from the reset vector.
    bif.i_read = 1; bif.i_address = 32'hBFC0_0000;
    txn(0, 32'hBFC0_0000, 32'h0, 4'hF, 0, 0, 32'h2402_0010);

    // Data read with a 5-cycle slave stall: completion at N+7.
    bif.d_read = 1; bif.d_address = 32'h1000_0003; bif.d_byteenable = 4'h8;
    txn(1, 32'h1000_0003, 32'h0, 4'h8, 0, 5, 32'hCAFE_F00D);

    // Read and write together: the write is issued.
    bif.d_read = 1; bif.d_write = 1; bif.d_address = 32'h2000_0000;
    bif.d_writedata = 32'h0BAD_F00D; bif.d_byteenable = 4'hC;
    txn(1, 32'h2000_0000, 32'h0BAD_F00D, 4'hC, 1, 2, 32'h0);

    // Hung slave: abort with zero data; the error stays set afterwards.
    bif.d_read = 1; bif.d_address = 32'h3000_0000; bif.d_byteenable = 4'hF;
    txn(1, 32'h3000_0000, 32'h0, 4'hF, 0, 100, 32'h7777_7777);
    bif.d_write = 1; bif.d_address = 32'h3000_0004;
    bif.d_writedata = 32'h1234_5678; bif.d_byteenable = 4'hF;
    txn(1, 32'h3000_0004, 32'h1234_5678, 4'hF, 1, 0, 32'h0);
    bif.i_read = 1; bif.i_address = 32'hBFC0_0020;
    txn(0, 32'hBFC0_0020, 32'h0, 4'hF, 0, 3, 32'h8888_9999);

    // Reset in the middle of a stalled data write.
    bif.d_write = 1; bif.d_address = 32'h4000_0000;
    bif.d_writedata = 32'hA5A5_A5A5; bif.d_byteenable = 4'hF;
    tick();
    bif.waitrequest = 1'b1;
    tick();
    tick();
    chk("mid_pre_write", bif.write, 1'b1);
    #3 reset = 1'b1;
    #1;
    chk("mid_write", bif.write, 1'b0);
    chk("mid_i_wait", bif.i_waitrequest, 1'b1);
    chk("mid_d_wait", bif.d_waitrequest, 1'b1);
    chk("mid_addr", bif.address, 32'h0);
    chk("mid_err", bif.bus_error, 1'b0);
    chk("mid_i_rdata", bif.i_readdata, 32'h0);
    last_g = 1'b1; exp_ird = '0; exp_drd = '0; exp_err = 1'b0;
    tick();
    reset = 1'b0;
    bif.i_read = 1; bif.i_address = 32'hBFC0_0040;
    txn(0, 32'hBFC0_0040, 32'h0, 4'hF, 0, 0, 32'hABCD_0001);
    txn(1, 32'h4000_0000, 32'hA5A5_A5A5, 4'hF, 1, 0, 32'h0);

    // Random mixes of one or two pending masters.
    for (int it = 0; it < 40; it++) begin
      bit          ir, dr, dwr, both_rw;
      logic [31:0] ia, da, dwd, ri, rd;
      logic [3:0]  dbe;
      int          si, sd;
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!ir && !dr) ir = 1'b1;
      dwr = 1'($urandom_range(0, 1));
      both_rw = 1'($urandom_range(0, 1));
      ia = $urandom; da = $urandom; dwd = $urandom; ri = $urandom; rd = $urandom;
      dbe = 4'($urandom_range(0, 15));
      si = ($urandom_range(0, 9) == 0) ? TMO + 4 : $urandom_range(0, 5);
      sd = ($urandom_range(0, 9) == 0) ? TMO + 4 : $urandom_range(0, 5);
      bif.i_read = ir; bif.i_address = ia;
      bif.d_write = dr && dwr;
      bif.d_read = dr && (!dwr || both_rw);
      bif.d_address = da; bif.d_writedata = dwd; bif.d_byteenable = dbe;
      if (ir && (!dr || last_g)) begin
        txn(0, ia, 32'h0, 4'hF, 0, si, ri);
        if (dr) txn(1, da, dwd, dbe, dwr, sd, rd);
      end else begin
        txn(1, da, dwd, dbe, dwr, sd, rd);
        if (ir) txn(0, ia, 32'h0, 4'hF, 0, si, ri);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
